// File: rtl/energy_calc_ctrl_if.sv
// energy_calc_ctrl_if: spin/weight/calculator/energy bus; master = sequencer, slave = core+SRAM+calculator side
interface energy_calc_ctrl_if #(
  parameter int DATASPIN = 256,
  parameter int BITJ = 4,
  parameter int BITH = 4,
  parameter int SCALING_BIT = 5,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int ENERGY_BIT = 24,
  parameter int ADDRW = $clog2(DATASPIN)
);
  logic spin_valid;
  logic spin_ready;
  logic [DATASPIN-1:0] spin;
  logic [SCALING_BIT-1:0] hscaling;
  logic weight_ren;
  logic [ADDRW-1:0] weight_raddr;
  logic weight_rvalid;
  logic [DATASPIN*BITJ-1:0] weight;
  logic [BITH-1:0] hbias;
  logic [DATASPIN-1:0] pe_spin;
  logic pe_current_spin;
  logic [DATASPIN*BITJ-1:0] pe_weight;
  logic [BITH-1:0] pe_hbias;
  logic [SCALING_BIT-1:0] pe_hscaling;
  logic [LOCAL_ENERGY_BIT-1:0] pe_energy;
  logic energy_valid;
  logic energy_ready;
  logic [ENERGY_BIT-1:0] energy;
  logic busy;
  modport master (
    input spin_valid, spin, hscaling, weight_rvalid, weight, hbias, pe_energy, energy_ready,
    output spin_ready, weight_ren, weight_raddr, pe_spin, pe_current_spin, pe_weight, pe_hbias,
    pe_hscaling, energy_valid, energy, busy
  );
  modport slave (
    output spin_valid, spin, hscaling, weight_rvalid, weight, hbias, pe_energy, energy_ready,
    input spin_ready, weight_ren, weight_raddr, pe_spin, pe_current_spin, pe_weight, pe_hbias,
    pe_hscaling, energy_valid, energy, busy
  );
endinterface

// File: rtl/energy_calc_ctrl.sv
// energy_calc_ctrl: walks spins 0..DATASPIN-1, fetches J row + h, sums calculator energies (ports: clk_i, rst_i async high, bus master)
module energy_calc_ctrl #(
  parameter int DATASPIN = 256,
  parameter int BITJ = 4,
  parameter int BITH = 4,
  parameter int SCALING_BIT = 5,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int ENERGY_BIT = 24,
  parameter int ADDRW = $clog2(DATASPIN)
) (
  input logic clk_i,
  input logic rst_i,
  energy_calc_ctrl_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] ACC = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(DATASPIN - 1);
  logic [2:0] state;
  logic [ADDRW-1:0] idx;
  logic [ENERGY_BIT-1:0] acc;
  logic [ENERGY_BIT-1:0] energy_ext;
  logic [DATASPIN-1:0] spin_reg;
  logic [SCALING_BIT-1:0] scaling_reg;
  logic [DATASPIN*BITJ-1:0] weight_reg;
  logic [BITH-1:0] hbias_reg;
  logic cur_spin;
  assign energy_ext = {{(ENERGY_BIT-LOCAL_ENERGY_BIT){bus.pe_energy[LOCAL_ENERGY_BIT-1]}}, bus.pe_energy};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      spin_reg <= '0;
      scaling_reg <= '0;
      weight_reg <= '0;
      hbias_reg <= '0;
      cur_spin <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.spin_valid) begin
          spin_reg <= bus.spin;
          scaling_reg <= bus.hscaling;
          idx <= '0;
          acc <= '0;
          state <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: if (bus.weight_rvalid) begin
          weight_reg <= bus.weight;
          hbias_reg <= bus.hbias;
          cur_spin <= spin_reg[idx];
          state <= ACC;
        end
        ACC: begin
          acc <= acc + energy_ext;
          state <= idx == LAST ? DONE : FETCH;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        DONE: if (bus.energy_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.spin_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.weight_ren = state == FETCH;
  assign bus.weight_raddr = state == FETCH ? idx : '0;
  assign bus.energy_valid = state == DONE;
  assign bus.energy = state == DONE ? acc : '0;
  assign bus.pe_spin = spin_reg;
  assign bus.pe_current_spin = cur_spin;
  assign bus.pe_weight = weight_reg;
  assign bus.pe_hbias = hbias_reg;
  assign bus.pe_hscaling = scaling_reg;
endmodule
